ram_sdp_clr: RTL and testbench



---
 rtl/ram_sdp_clr.sv | 67 ++++++
 tb/tb_ram_sdp_clr.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr: simple-dual-port RAM with registered read, valid strobe and hardware clear sweep.
// Defining RAM_BYPASS_EN makes a same-cycle, same-address read return the write data.
module ram_sdp_clr #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              busy_o
);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt, waddr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wdata, rd_word;
  logic idle, last, wr_acc, rd_acc, we;
  assign idle = state == IDLE;
  assign last = ptr == ADDR_W'(DEPTH - 1);
  assign wr_acc = idle && !clr_i && wr_en_i && 32'(wr_addr_i) < DEPTH;
  assign rd_acc = idle && !clr_i && rd_en_i;
  assign busy_o = !idle;
  always_comb begin
    state_nxt = state;
    ptr_nxt = ptr;
    if (!idle) begin
      state_nxt = last ? IDLE : CLEAR;
      ptr_nxt = last ? ptr : ptr + 1'b1;
    end else if (clr_i) begin
      state_nxt = CLEAR;
      ptr_nxt = '0;
    end
  end
  // The sweep and the write port share one memory write path.
  assign we = !idle || wr_acc;
  assign waddr = idle ? wr_addr_i : ptr;
  assign wdata = idle ? wr_data_i : FILL_VALUE;
  always_ff @(posedge clk_i)
    if (we) mem[waddr] <= wdata;
`ifdef RAM_BYPASS_EN
  assign rd_word = (wr_acc && wr_addr_i == rd_addr_i) ? wr_data_i :
                   32'(rd_addr_i) < DEPTH ? mem[rd_addr_i] : FILL_VALUE;
`else
  assign rd_word = 32'(rd_addr_i) < DEPTH ? mem[rd_addr_i] : FILL_VALUE;
`endif
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= CLEAR;
      ptr <= '0;
      rd_data_o <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      rd_valid_o <= rd_acc;
      if (rd_acc) rd_data_o <= rd_word;
    end
endmodule

// File: tb/tb_ram_sdp_clr.sv
// tb_ram_sdp_clr: directed bench for ram_sdp_clr, full-depth instance plus a DEPTH=200 / fill 0xA instance.
module tb_ram_sdp_clr;
  logic clk = 1'b0;
  logic rst_n, clr, wr_en, rd_en;
  logic [7:0] wr_addr, rd_addr;
  logic [3:0] wr_data, rd_data, rd_data2;
  logic rd_valid, busy, rd_valid2, busy2;
  int errors = 0;
  int checks = 0;
  int n, vcount;
  logic anyv;
  logic [7:0] ra [4] = '{8'd3, 8'd15, 8'd63, 8'd255};
  logic [3:0] rv [4] = '{4'd1, 4'd3, 4'd7, 4'd15};

  always #5 clk = ~clk;

  ram_sdp_clr dut (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_valid_o(rd_valid), .busy_o(busy)
  );

  ram_sdp_clr #(.DEPTH(200), .FILL_VALUE(4'hA)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data2),
    .rd_valid_o(rd_valid2), .busy_o(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [3:0] exp, input string tag);
    rd_en = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, rd_valid, 1);
    chk({tag, "_data"}, rd_data, exp);
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    #20;
    chk("rst_busy", busy, 1);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    #2 rst_n = 1'b1;
    chk("rel_busy", busy, 1);
    wait_idle(n);
    chk("init_clear_len", n, 256);
    chk("dut2_idle", busy2, 0);
    rd(8'd200, 4'd0, "rd200");
    tick();
    chk("rd200_pulse", rd_valid, 0);
    for (int i = 0; i < 4; i++) wr(ra[i], rv[i]);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      rd_addr = ra[i];
      tick();
      chk("b2b_data", rd_data, rv[i]);
      vcount += int'(rd_valid);
    end
    rd_en = 1'b0;
    tick();
    vcount += int'(rd_valid);
    chk("b2b_valid_cnt", vcount, 4);
    chk("hold_data", rd_data, 15);
    wr(8'd10, 4'd5);
    wr_en = 1'b1; wr_addr = 8'd10; wr_data = 4'd9;
    rd_en = 1'b1; rd_addr = 8'd10;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
`ifdef RAM_BYPASS_EN
    chk("rdw_data", rd_data, 9);
`else
    chk("rdw_data", rd_data, 5);
`endif
    rd(8'd10, 4'd9, "rdw_after");
    for (int i = 0; i < 256; i++) wr(8'(i), 4'd15);
    rd(8'd128, 4'd15, "fill");
    clr = 1'b1; wr_en = 1'b1; wr_addr = 8'd0; wr_data = 4'd6;
    rd_en = 1'b1; rd_addr = 8'd0;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    chk("clr_wins_valid", rd_valid, 0);
    chk("clr_busy", busy, 1);
    // Keep reading throughout the sweep; also poke a write and a second clr mid-sweep.
    n = 0;
    anyv = 1'b0;
    while (busy && n < 400) begin
      wr_en = n == 50;
      wr_addr = 8'd5;
      wr_data = 4'd6;
      clr = n == 100;
      tick();
      n++;
      anyv |= rd_valid;
    end
    rd_en = 1'b0; wr_en = 1'b0; clr = 1'b0;
    chk("soft_clear_len", n, 256);
    chk("sweep_no_valid", anyv, 0);
    for (int i = 0; i < 256; i++) begin
      rd_en = 1'b1;
      rd_addr = 8'(i);
      tick();
      chk("cleared", {rd_valid, rd_data}, 5'h10);
    end
    rd_en = 1'b0;
    wr(8'd7, 4'd12);
    rd(8'd7, 4'd12, "pre_rst");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (100) tick();
    chk("mid_busy", busy, 1);
    chk("mid_hold", rd_data, 12);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_data", rd_data, 0);
    chk("mid_rst_valid", rd_valid, 0);
    tick();
    rst_n = 1'b1;
    wait_idle(n);
    chk("mid_rst_clear_len", n, 256);
    chk("dut2_idle2", busy2, 0);
    wr(8'd220, 4'd3);
    rd_en = 1'b1; rd_addr = 8'd220;
    tick();
    rd_en = 1'b0;
    chk("oor_data", rd_data2, 4'hA);
    chk("oor_valid", rd_valid2, 1);
    chk("full_220", rd_data, 3);
    wr(8'd199, 4'd5);
    rd_en = 1'b1; rd_addr = 8'd199;
    tick();
    chk("edge199", rd_data2, 5);
    rd_addr = 8'd20;
    tick();
    rd_en = 1'b0;
    chk("dut2_fill", rd_data2, 4'hA);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
